// File: rtl/serial_parallel.sv
`default_nettype none
// ============================================================================
//  Module      : serial_parallel
//  Description : Deserializer for an LSB-first serial stream qualified by
//                valid_i. Assembles WIDTH-bit words into a single-entry
//                output register that is drained by a valid/ready handshake.
//                A word that completes while the register is still full is
//                dropped and reported on overrun_o.
//
//  Ports       : clk          rising-edge clock
//                reset        asynchronous active-high reset
//                serial_i     serial data bit, LSB of the word first
//                valid_i      serial_i carries a valid bit this cycle
//                parallel_o   assembled word, stable while valid_o = 1
//                valid_o      output register holds an unconsumed word
//                ready_i      consumer accepts the word when valid_o & ready_i
//                overrun_o    one-cycle pulse: a completed word was dropped
//                frame_err_o  one-cycle pulse: a partial word was aborted
//
//  Options     : S2P_GAP_CHECK_EN - when defined, a valid_i gap in the middle
//                of a word aborts it and pulses frame_err_o. When undefined,
//                a gap only pauses assembly and frame_err_o is tied to 0.
//
//  Revision    : 1.0  initial release
// ============================================================================
module serial_parallel #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] parallel_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             overrun_o,
    output logic             frame_err_o
);

    localparam int                 c_CNT_W   = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(WIDTH - 1);

    // Only the upper WIDTH-1 bits of the shift register are kept: the lowest
    // bit would be shifted out on the very edge that completes the word, so
    // it is never observed. r_sr[i] corresponds to shift position i+1.
    logic [WIDTH-2:0]   r_sr;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_out;
    logic               r_full;
    logic               r_overrun;

    logic [WIDTH-1:0]   w_word;
    logic               w_last;
    logic               w_drain;
    logic               w_load;

    // The shifted-in value; on the final bit this is also the finished word,
    // with the last bit taken straight from the input.
    assign w_word  = {serial_i, r_sr};
    assign w_last  = valid_i && (r_cnt == c_CNT_MAX);
    assign w_drain = r_full && ready_i;
    // A full register may still take the new word if it empties this cycle.
    assign w_load  = w_last && (!r_full || ready_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr      <= '0;
            r_cnt     <= '0;
            r_out     <= '0;
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_last && r_full && !ready_i;

            if (valid_i) begin
                r_sr  <= w_word[WIDTH-1:1];
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
`ifdef S2P_GAP_CHECK_EN
            else if (r_cnt != '0) begin
                // Gap inside a word: throw the partial word away.
                r_sr  <= '0;
                r_cnt <= '0;
            end
`endif

            if (w_load) begin
                r_out  <= w_word;
                r_full <= 1'b1;
            end else if (w_drain) begin
                r_full <= 1'b0;
            end
        end
    end

`ifdef S2P_GAP_CHECK_EN
    logic r_frame_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= !valid_i && (r_cnt != '0);
        end
    end

    assign frame_err_o = r_frame_err;
`else
    assign frame_err_o = 1'b0;
`endif

    assign parallel_o = r_out;
    assign valid_o    = r_full;
    assign overrun_o  = r_overrun;

endmodule
`default_nettype wire

// File: doc/serial_parallel.md
# serial_parallel

Deserializer directly downstream of the 4-bit parallel-to-serial stage. It samples a serial bit stream qualified by `valid_i`, LSB first, and assembles WIDTH-bit words. Each completed word goes into a single-entry output register drained by a valid/ready handshake. Overrun is reported when a new word completes while the output register is still full, and optional frame-gap checking is available.

## Interface
- `WIDTH`, default 4: bits per word; legal range 2..32; matches the upstream serializer width.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `serial_i`  input  1  serial data bit, LSB of word first.
- `valid_i`  input  1  `serial_i` carries a valid bit this cycle.
- `parallel_o`  output  WIDTH  assembled word; stable while `valid_o`=1.
- `valid_o`  output  1  output register holds an unconsumed word.
- `ready_i`  input  1  consumer accepts `parallel_o` when `valid_o`&`ready_i`.
- `overrun_o`  output  1  one-cycle pulse: a completed word was dropped.
- `frame_err_o`  output  1  one-cycle pulse: partial word aborted (only with `S2P_GAP_CHECK_EN`; otherwise tied 0).

## Operation
- State:
  - shift register `sr[WIDTH-1:0]`.
  - bit counter `cnt`, width `$clog2(WIDTH)`, range 0..WIDTH-1.
  - output register `out_q`, with full flag `full_q` (drives `valid_o`).
- Bit capture: on a cycle with `valid_i`=1:
  - `sr <= {serial_i, sr[WIDTH-1:1]}`. After WIDTH bits, the first bit sits at bit 0.
  - `cnt <= (cnt==WIDTH-1) ? 0 : cnt+1`, wrapping with no idle cycle required.
- Word completion (`valid_i` & `cnt==WIDTH-1`):
  - The completed word is `{serial_i, sr[WIDTH-1:1]}`, with the final bit taken directly from the input.
  - If `full_q`=0, or the register is drained this cycle (`valid_o`&`ready_i`), load `out_q` and set `full_q`=1.
  - Otherwise drop the word, keep `out_q` unchanged, and pulse `overrun_o` next cycle.
- Drain: `valid_o`&`ready_i` with no simultaneous load clears `full_q`. `parallel_o` keeps its last value, without being cleared.
- `valid_i`=0 mid-word, without the macro: `cnt` and `sr` hold, and the word resumes when `valid_i` returns.
- `ready_i` is ignored while `valid_o`=0.
- `valid_o` must not depend combinationally on `ready_i`.
- Reset, asynchronous and mid-operation allowed:
  - `sr`=0, `cnt`=0, `full_q`=0.
  - `parallel_o`=0, `valid_o`=0, `overrun_o`=0, `frame_err_o`=0.
  - Any partial or held word is discarded.

## Timing
- Latency: the last bit is sampled at edge N, and `valid_o`=1 with the word from edge N onward, i.e. the cycle after the last valid bit.
- Throughput: one word per WIDTH valid cycles. With the 4-bit upstream stage (4 valid, 1 idle), one word per 5 cycles.
- Backpressure:
  - The word is held until accepted.
  - A load and a drain in the same cycle keep `valid_o`=1 with the new word, with no bubble.
- `overrun_o` and `frame_err_o` are registered single-cycle pulses, asserted the cycle after the triggering edge.
- All outputs are registered.

## Configuration
- `S2P_GAP_CHECK_EN` defined:
  - A cycle with `valid_i`=0 while `cnt`!=0 aborts the partial word: `cnt`=0 and `sr`=0.
  - `frame_err_o` pulses on the next cycle.
  - The output register is unaffected.
  - The idle cycle after a complete word (`cnt`==0) is legal.
- Not defined: a gap pauses assembly, and `frame_err_o` is constant 0.

## Test plan
- WIDTH=4, `ready_i`=1: bits 1,0,1,1 on consecutive cycles -> `parallel_o`=4'hD, `valid_o`=1 for exactly one cycle after the 4th bit.
- Chained with the upstream 4-bit serializer, `parallel_i`=4'hA held -> `parallel_o`=4'hA, with `valid_o` pulsing every 5 cycles.
- `ready_i`=0, words 4'h3 then 4'hC -> `parallel_o` stays 4'h3, `overrun_o` pulses once one cycle after the second word's last bit. Then `ready_i`=1 -> one transfer of 4'h3, `valid_o` drops.
- `valid_o`=1 holding 4'h5; the next word 4'h9 completes in the same cycle as `ready_i`=1 -> `valid_o` stays 1, `parallel_o`=4'h9, no overrun.
- Gap after 2 bits, then 4 bits 0,1,1,0:
  - With `S2P_GAP_CHECK_EN` -> `frame_err_o` pulse, then `parallel_o`=4'h6.
  - Without -> the first two bits are kept, and the word completes after 2 more bits.
- `reset` asserted after 3 bits and with `valid_o`=1 -> all outputs 0 immediately. The next 4 bits 1,1,1,1 produce 4'hF with no residue.
